multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_pkg.sv | 42 ++++
 rtl/alu_decoder.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit:
// FSM state codes, datapath select codes and ALU function opcodes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RM  = 2'b00;
  localparam logic [1:0] SRCB_EXT = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_ADD = 4'b0100;
  localparam logic [3:0] FN_CMP = 4'b1010;
  localparam logic [3:0] FN_ORR = 4'b1100;
  localparam logic [3:0] FN_MOV = 4'b1101;

endpackage

// File: rtl/alu_decoder.sv
// ALU function decoder: maps Funct[4:1] to ALU op, flag-write mask and write suppression.
// Purely combinational, zero latency, no flow control.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic       i_alu_op,
  input  logic [5:0] i_funct,
  output logic [1:0] o_alu_control,
  output logic [1:0] o_flag_w0,
  output logic       o_no_write,
  output logic       o_shift,
  output logic       o_illegal_funct
);

  logic w_arith;

  always_comb begin
    o_alu_control   = ALU_ADD;
    o_flag_w0       = 2'b00;
    o_no_write      = 1'b0;
    o_shift         = 1'b0;
    o_illegal_funct = 1'b0;
    w_arith         = 1'b0;
    if (i_alu_op) begin
      case (i_funct[4:1])
        FN_ADD: begin o_alu_control = ALU_ADD; w_arith = 1'b1; end
        FN_SUB: begin o_alu_control = ALU_SUB; w_arith = 1'b1; end
        FN_AND: o_alu_control = ALU_AND;
        FN_ORR: o_alu_control = ALU_ORR;
        FN_CMP: begin o_alu_control = ALU_SUB; w_arith = 1'b1; o_no_write = 1'b1; end
        FN_MOV: o_shift = 1'b1;
        default: begin o_illegal_funct = 1'b1; o_no_write = 1'b1; end
      endcase
      // An unimplemented function must leave the flags untouched too.
      if (!o_illegal_funct)
        o_flag_w0 = {i_funct[0], i_funct[0] & w_arith};
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: FSM, per-state datapath selects, condition gating, retire counter.
// Outputs are combinational from state and IR fields; 2-5 cycles per instruction, never stalls.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic             CondEx,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemW,
  output logic             IRWrite,
  output logic             RegW,
  output logic [1:0]       ResultSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [1:0]       ALUControl,
  output logic [1:0]       FlagW,
  output logic             Shift,
  output logic             Illegal,
  output logic             Retired,
  output logic [CNT_W-1:0] RetireCnt,
  output logic [3:0]       State
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retire_cnt;

  logic       w_alu_op;
  logic       w_next_pc;
  logic       w_branch;
  logic       w_reg_w0;
  logic       w_mem_w0;
  logic       w_illegal_op;
  logic       w_retired;
  logic [1:0] w_flag_w0;
  logic       w_no_write;
  logic       w_illegal_funct;

  assign w_alu_op = (r_state == S_EXECR) || (r_state == S_EXECI);

  alu_decoder u_alu_decoder (
    .i_alu_op        (w_alu_op),
    .i_funct         (Funct),
    .o_alu_control   (ALUControl),
    .o_flag_w0       (w_flag_w0),
    .o_no_write      (w_no_write),
    .o_shift         (Shift),
    .o_illegal_funct (w_illegal_funct)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = S_FETCH;
    w_next_pc    = 1'b0;
    w_branch     = 1'b0;
    w_reg_w0     = 1'b0;
    w_mem_w0     = 1'b0;
    w_illegal_op = 1'b0;
    w_retired    = 1'b0;
    IRWrite      = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_RM;
    ResultSrc    = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_next    = S_DECODE;
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        w_next_pc = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        case (Op)
          OP_DP:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  w_next = S_MEMADR;
          OP_BR:   w_next = S_BRANCH;
          default: begin w_next = S_FETCH; w_illegal_op = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_EXT;
        w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        w_reg_w0  = 1'b1;
        w_retired = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        w_mem_w0  = 1'b1;
        w_retired = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB = (r_state == S_EXECI) ? SRCB_EXT : SRCB_RM;
        if (w_no_write) begin
          w_next    = S_FETCH;
          w_retired = !w_illegal_funct;
        end else begin
          w_next    = S_ALUWB;
        end
      end
      S_ALUWB: begin
        w_reg_w0  = 1'b1;
        w_retired = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_EXT;
        ResultSrc = RES_ALU;
        w_branch  = 1'b1;
        w_retired = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // STR differs from LDR only in where the store data register comes from.
  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      OP_MEM: begin ImmSrc = 2'b01; RegSrc = Funct[0] ? 2'b00 : 2'b10; end
      OP_BR:  begin ImmSrc = 2'b10; RegSrc = 2'b01; end
      default: ;
    endcase
  end

  assign RegW    = w_reg_w0 & CondEx;
  assign MemW    = w_mem_w0 & CondEx;
  assign FlagW   = w_flag_w0 & {2{CondEx}};
  assign PCWrite = w_next_pc | (CondEx & (w_branch | (w_reg_w0 & (Rd == 4'd15))));
  assign Illegal = w_illegal_op | w_illegal_funct;
  assign Retired = w_retired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_retire_cnt <= '0;
    else if (w_retired) r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign RetireCnt = r_retire_cnt;
  assign State     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares state, control vector and retire count.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic        CondEx;
  logic        PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, Shift, Illegal, Retired;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW;
  logic [15:0] RetireCnt;
  logic [3:0]  State;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW), .IRWrite(IRWrite), .RegW(RegW),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW), .Shift(Shift),
    .Illegal(Illegal), .Retired(Retired), .RetireCnt(RetireCnt), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl bit order: PCWrite AdrSrc MemW IRWrite RegW | ResultSrc ALUSrcA ALUSrcB |
  //                ImmSrc RegSrc | ALUControl FlagW Shift Illegal Retired
  logic [20:0] w_ctl;
  assign w_ctl = {PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, RegSrc, ALUControl, FlagW, Shift, Illegal, Retired};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [20:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  string cur_tag = "reset";

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic push(input logic [3:0] st, input logic [20:0] ctl, input logic [15:0] cnt);
    exp_t e;
    e.tag = cur_tag; e.st = st; e.ctl = ctl; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] st, input logic [20:0] ctl, input logic [15:0] cnt);
    push(st, ctl, cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] rd, input logic cx);
    cur_tag = tag; Op = op; Funct = fn; Rd = rd; CondEx = cx;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.tag, ".state"}, {28'd0, State}, {28'd0, e.st});
        check({e.tag, ".ctl"}, {11'd0, w_ctl}, {11'd0, e.ctl});
        check({e.tag, ".cnt"}, {16'd0, RetireCnt}, {16'd0, e.cnt});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b0;
    push(4'd0, 21'b10010_10110_0000_0000000, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    instr("add_reg", 2'b00, 6'b001000, 4'd2, 1'b1);
    cyc(4'd0, 21'b10010_10110_0000_0000000, 16'd0);
    cyc(4'd1, 21'b00000_10110_0000_0000000, 16'd0);
    cyc(4'd6, 21'b00000_00000_0000_0000000, 16'd0);
    cyc(4'd8, 21'b00001_00000_0000_0000001, 16'd0);

    instr("ldr", 2'b01, 6'b011001, 4'd3, 1'b1);
    cyc(4'd0, 21'b10010_10110_0100_0000000, 16'd1);
    cyc(4'd1, 21'b00000_10110_0100_0000000, 16'd1);
    cyc(4'd2, 21'b00000_00001_0100_0000000, 16'd1);
    cyc(4'd3, 21'b01000_00000_0100_0000000, 16'd1);
    cyc(4'd4, 21'b00001_01000_0100_0000001, 16'd1);

    instr("str_squash", 2'b01, 6'b011000, 4'd3, 1'b0);
    cyc(4'd0, 21'b10010_10110_0110_0000000, 16'd2);
    cyc(4'd1, 21'b00000_10110_0110_0000000, 16'd2);
    cyc(4'd2, 21'b00000_00001_0110_0000000, 16'd2);
    cyc(4'd5, 21'b01000_00000_0110_0000001, 16'd2);

    instr("cmp_s", 2'b00, 6'b010101, 4'd0, 1'b1);
    cyc(4'd0, 21'b10010_10110_0000_0000000, 16'd3);
    cyc(4'd1, 21'b00000_10110_0000_0000000, 16'd3);
    cyc(4'd6, 21'b00000_00000_0000_0111001, 16'd3);

    instr("b_nt", 2'b10, 6'b000000, 4'd0, 1'b0);
    cyc(4'd0, 21'b10010_10110_1001_0000000, 16'd4);
    cyc(4'd1, 21'b00000_10110_1001_0000000, 16'd4);
    cyc(4'd9, 21'b00000_10001_1001_0000001, 16'd4);

    instr("b_taken", 2'b10, 6'b000000, 4'd0, 1'b1);
    cyc(4'd0, 21'b10010_10110_1001_0000000, 16'd5);
    cyc(4'd1, 21'b00000_10110_1001_0000000, 16'd5);
    cyc(4'd9, 21'b10000_10001_1001_0000001, 16'd5);

    instr("add_imm_pc", 2'b00, 6'b101000, 4'd15, 1'b1);
    cyc(4'd0, 21'b10010_10110_0000_0000000, 16'd6);
    cyc(4'd1, 21'b00000_10110_0000_0000000, 16'd6);
    cyc(4'd7, 21'b00000_00001_0000_0000000, 16'd6);
    cyc(4'd8, 21'b10001_00000_0000_0000001, 16'd6);

    instr("illegal_op", 2'b11, 6'b000000, 4'd0, 1'b1);
    cyc(4'd0, 21'b10010_10110_0000_0000000, 16'd7);
    cyc(4'd1, 21'b00000_10110_0000_0000010, 16'd7);

    instr("illegal_fn", 2'b00, 6'b000110, 4'd1, 1'b1);
    cyc(4'd0, 21'b10010_10110_0000_0000000, 16'd7);
    cyc(4'd1, 21'b00000_10110_0000_0000000, 16'd7);
    cyc(4'd6, 21'b00000_00000_0000_0000010, 16'd7);

    instr("mov_shift", 2'b00, 6'b011010, 4'd1, 1'b1);
    cyc(4'd0, 21'b10010_10110_0000_0000000, 16'd7);
    cyc(4'd1, 21'b00000_10110_0000_0000000, 16'd7);
    cyc(4'd6, 21'b00000_00000_0000_0000100, 16'd7);
    cyc(4'd8, 21'b00001_00000_0000_0000001, 16'd7);

    instr("subs_squash", 2'b00, 6'b000101, 4'd15, 1'b0);
    cyc(4'd0, 21'b10010_10110_0000_0000000, 16'd8);
    cyc(4'd1, 21'b00000_10110_0000_0000000, 16'd8);
    cyc(4'd6, 21'b00000_00000_0000_0100000, 16'd8);
    cyc(4'd8, 21'b00000_00000_0000_0000001, 16'd8);

    instr("ldr_reset", 2'b01, 6'b011001, 4'd3, 1'b1);
    cyc(4'd0, 21'b10010_10110_0100_0000000, 16'd9);
    cyc(4'd1, 21'b00000_10110_0100_0000000, 16'd9);
    cyc(4'd2, 21'b00000_00001_0100_0000000, 16'd9);
    // Now in MEMRD; reset lands between clock edges and must act at once.
    #1 reset = 1'b1;
    cur_tag = "async_reset";
    push(4'd0, 21'b10010_10110_0100_0000000, 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    instr("add_after_reset", 2'b00, 6'b001000, 4'd2, 1'b1);
    cyc(4'd0, 21'b10010_10110_0000_0000000, 16'd0);
    cyc(4'd1, 21'b00000_10110_0000_0000000, 16'd0);
    cyc(4'd6, 21'b00000_00000_0000_0000000, 16'd0);
    cyc(4'd8, 21'b00001_00000_0000_0000001, 16'd0);
    cur_tag = "post";
    cyc(4'd0, 21'b10010_10110_0000_0000000, 16'd1);

    repeat (2) @(posedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
